mealy_seq_detector: RTL and testbench

Parametrised Mealy-type serial pattern detector, successor to the fixed 4-state Mealy FSM. Compares a serial bit stream against a runtime-loadable PAT_W-bit pattern and raises a same-cycle Mealy `out` on the bit that completes a match. Supports overlapping and non-overlapping detection, input qualification and an optional saturating hit counter. Sits between the input synchroniser/debouncer and the LED/status logic.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_det_hit_counter.sv | 35 +++
 rtl/mealy_seq_detector.sv | 116 +++++++++++
 tb/tb_mealy_seq_detector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and parameter bounds for the serial pattern detector.
// Optional hit counter is enabled with SEQ_DET_HIT_CNT_EN.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        RUN  = 2'b10
    } state_e;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/seq_det_hit_counter.sv
// Saturating hit counter; clr has priority over inc.
// Only instantiated when SEQ_DET_HIT_CNT_EN is defined.
module seq_det_hit_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector with runtime-loadable pattern.
// Define SEQ_DET_HIT_CNT_EN to build the saturating hit counter.
module mealy_seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             out,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] hit_count
);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("mealy_seq_detector: PAT_W out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("mealy_seq_detector: CNT_W out of range");
    end

    localparam int FILL_W = $clog2(PAT_W);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_W-1:0]   cand;
    logic               hit;

    assign cand = {hist_q, in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (load) begin
            pat_d   = pattern;
            ovl_d   = overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else begin
            unique case (state_q)
                IDLE: ;
                FILL: begin
                    if (in_valid) begin
                        hist_d = cand[PAT_W-2:0];
                        fill_d = fill_q + 1'b1;
                        if (fill_q == FILL_W'(PAT_W - 2)) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        hist_d = cand[PAT_W-2:0];
                        // Non-overlap restarts the fill so a hit needs PAT_W fresh bits
                        if (hit && !ovl_q) begin
                            state_d = FILL;
                            fill_d  = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hit     = in_valid && (state_q == RUN) && (cand == pat_q)
                  && !load && !rst;
        out     = hit;
        state_o = state_q;
    end

`ifdef SEQ_DET_HIT_CNT_EN
    seq_det_hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (load),
        .count (hit_count)
    );
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Randomised and directed bench for mealy_seq_detector against a
// queue-based reference model of the detection rules.
module tb_mealy_seq_detector;

    localparam int PW = 4;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          din = 1'b0;
    logic          load = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic          overlap = 1'b0;
    logic          out;
    logic [1:0]    state_o;
    logic [CW-1:0] hit_count;

    mealy_seq_detector #(
        .PAT_W (PW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .load      (load),
        .pattern   (pattern),
        .overlap   (overlap),
        .out       (out),
        .state_o   (state_o),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bits seen since the last load, and how many
    // of them count toward the next match window.
    bit            m_loaded = 0;
    bit            m_ovl = 0;
    logic [PW-1:0] m_pat = '0;
    int            m_n = 0;
    bit            m_q[$];
    int            m_cnt = 0;

    logic          go, ge;
    logic [1:0]    sg, se;
    logic [CW-1:0] cg, ce;

    task automatic drive(input logic r, input logic v, input logic b,
                         input logic ld, input logic [PW-1:0] p,
                         input logic ovl);
        logic [PW-1:0] c;
        logic          e_hit;
        rst = r; in_valid = v; din = b;
        load = ld; pattern = p; overlap = ovl;
        @(negedge clk);
        e_hit = 1'b0;
        if (!r && !ld && v && m_loaded && m_n >= PW - 1) begin
            c = '0;
            c[0] = b;
            for (int k = 1; k < PW; k++) c[k] = m_q[m_q.size() - k];
            e_hit = (c == m_pat);
        end
        go = out;
        ge = e_hit;
        sg = state_o;
        se = !m_loaded ? 2'b00 : (m_n >= PW - 1 ? 2'b10 : 2'b01);
        cg = hit_count;
`ifdef SEQ_DET_HIT_CNT_EN
        ce = CW'(m_cnt);
`else
        ce = '0;
`endif
        if (r) begin
            m_loaded = 0; m_ovl = 0; m_pat = '0;
            m_n = 0; m_q.delete(); m_cnt = 0;
        end else if (ld) begin
            m_loaded = 1; m_ovl = ovl; m_pat = p;
            m_n = 0; m_q.delete(); m_cnt = 0;
        end else if (v && m_loaded) begin
            m_q.push_back(b);
            if (m_q.size() > PW) void'(m_q.pop_front());
            m_n++;
            if (e_hit) begin
                if (m_cnt < CMAX) m_cnt++;
                if (!m_ovl) m_n = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, '0, 0);
        n_cmp++;
        if (go !== 1'b0) begin
            n_err++; $display("FAIL rst_out: got %b want 0", go);
        end
        drive(1, 1, 1, 0, '0, 0);
        n_cmp++;
        if (sg !== 2'b00 || go !== 1'b0 || cg !== '0) begin
            n_err++;
            $display("FAIL rst_state: got st=%b out=%b cnt=%0d want 00/0/0",
                     sg, go, cg);
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1'($urandom), 0, '0, 0);
            n_cmp++;
            if (go !== 1'b0 || sg !== 2'b00 || cg !== '0) begin
                n_err++;
                $display("FAIL noload[%0d]: got out=%b st=%b cnt=%0d want 0/00/0",
                         i, go, sg, cg);
            end
        end
    endtask

    task automatic test_1011(input logic ovl, input logic gaps);
        logic [6:0] bits;
        int         hits;
        bits = 7'b1011011;
        hits = 0;
        drive(0, 1, 1, 1, 4'b1011, ovl);
        n_cmp++;
        if (go !== 1'b0) begin
            n_err++; $display("FAIL ld_out ovl=%b: got %b want 0", ovl, go);
        end
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, bits[6-i], 0, '0, 0);
            hits += int'(go);
            n_cmp++;
            if (go !== ge || sg !== se || cg !== ce) begin
                n_err++;
                $display("FAIL p1011 ovl=%b gap=%b bit%0d: got %b/%b/%0d want %b/%b/%0d",
                         ovl, gaps, i + 1, go, sg, cg, ge, se, ce);
            end
            if (gaps) begin
                drive(0, 0, ~bits[6-i], 0, '0, 0);
                n_cmp++;
                if (go !== 1'b0 || sg !== se) begin
                    n_err++;
                    $display("FAIL gap%0d: got out=%b st=%b want 0/%b",
                             i, go, sg, se);
                end
            end
        end
        n_cmp++;
        if (hits != (ovl ? 2 : 1)) begin
            n_err++;
            $display("FAIL p1011_hits ovl=%b: got %0d want %0d",
                     ovl, hits, ovl ? 2 : 1);
        end
    endtask

    task automatic test_all_ones(input logic ovl);
        int hits;
        hits = 0;
        drive(0, 0, 0, 1, 4'b1111, ovl);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 1, 0, '0, 0);
            hits += int'(go);
            n_cmp++;
            if (go !== ge || cg !== ce) begin
                n_err++;
                $display("FAIL ones ovl=%b bit%0d: got %b/%0d want %b/%0d",
                         ovl, i + 1, go, cg, ge, ce);
            end
        end
        n_cmp++;
        if (hits != (ovl ? 5 : 2)) begin
            n_err++;
            $display("FAIL ones_hits ovl=%b: got %0d want %0d",
                     ovl, hits, ovl ? 5 : 2);
        end
    endtask

    task automatic test_load_midstream();
        drive(0, 1, 1, 1, 4'b0110, 1);
        n_cmp++;
        if (go !== 1'b0) begin
            n_err++; $display("FAIL midld_out: got %b want 0", go);
        end
        drive(0, 0, 0, 0, '0, 0);
        n_cmp++;
        if (sg !== 2'b01 || cg !== '0 || sg !== se) begin
            n_err++;
            $display("FAIL midld_state: got st=%b cnt=%0d want 01/0", sg, cg);
        end
    endtask

    task automatic test_reset_midmatch();
        drive(0, 0, 0, 1, 4'b1011, 1);
        drive(0, 1, 1, 0, '0, 0);
        drive(0, 1, 0, 0, '0, 0);
        drive(0, 1, 1, 0, '0, 0);
        drive(1, 1, 1, 0, '0, 0);
        n_cmp++;
        if (go !== 1'b0) begin
            n_err++; $display("FAIL rstmid_out: got %b want 0", go);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1'($urandom), 0, '0, 0);
            n_cmp++;
            if (sg !== 2'b00 || go !== 1'b0 || cg !== '0) begin
                n_err++;
                $display("FAIL rstmid_after%0d: got %b/%b/%0d want 00/0/0",
                         i, sg, go, cg);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic r, v, b, ld, ov;
        logic [PW-1:0] p;
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            ov = 1'($urandom);
            p  = ($urandom_range(0, 3) == 0) ? 4'b1111 : PW'($urandom);
            drive(r, v, b, ld, p, ov);
            n_cmp++;
            if (go !== ge || sg !== se || cg !== ce) begin
                n_err++;
                $display("FAIL rand cyc%0d: got %b/%b/%0d want %b/%b/%0d",
                         i, go, sg, cg, ge, se, ce);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_1011(1, 0);
        test_1011(0, 0);
        test_all_ones(1);
        test_all_ones(0);
        test_1011(1, 1);
        test_all_ones(1);
        test_load_midstream();
        test_reset_midmatch();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
